// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module      : alu_sequencer_if
// Description : Request/response handshake bundle for alu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
  parameter int BIT_WIDTH = 1
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [BIT_WIDTH-1:0] req_a;
  logic [BIT_WIDTH-1:0] req_b;
  logic                 req_acc;
  logic                 res_valid;
  logic                 res_ready;
  logic [BIT_WIDTH-1:0] res_data;
  logic                 res_cout;

  modport master (
    output req_valid, req_op, req_a, req_b, req_acc, res_ready,
    input  req_ready, res_valid, res_data, res_cout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_acc, res_ready,
    output req_ready, res_valid, res_data, res_cout
  );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Load-A / load-B / execute / write-back controller for the
//               registered ALU datapath. Optional accumulate mode is enabled
//               by defining ALU_SEQ_ACC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int BIT_WIDTH = 1,
  parameter int CNT_WIDTH = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  alu_sequencer_if.slave            bus,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      op_count,
  output logic [BIT_WIDTH-1:0]      dp_in,
  output logic [1:0]                dp_reg_addr,
  output logic                      dp_s_reg,
  output logic                      dp_s,
  input  wire logic [BIT_WIDTH-1:0] dp_out,
  input  wire logic                 dp_cout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  localparam logic [1:0] C_ADDR_A    = 2'd0;
  localparam logic [1:0] C_ADDR_B    = 2'd1;
  localparam logic [1:0] C_ADDR_O    = 2'd2;
  localparam logic [1:0] C_ADDR_NONE = 2'd3;

  state_t                state_q, state_d;
  logic                  op_q, op_d;
  logic [BIT_WIDTH-1:0]  a_q, a_d;
  logic [BIT_WIDTH-1:0]  b_q, b_d;
  logic [BIT_WIDTH-1:0]  res_data_q, res_data_d;
  logic                  res_cout_q, res_cout_d;
  logic                  res_valid_q, res_valid_d;
  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;
  logic [BIT_WIDTH-1:0]  dp_in_q, dp_in_d;
  logic [1:0]            dp_reg_addr_q, dp_reg_addr_d;
  logic                  dp_s_reg_q, dp_s_reg_d;
  logic                  dp_s_q, dp_s_d;
  logic                  use_acc;

`ifdef ALU_SEQ_ACC_EN
  logic acc_q, acc_d;
  logic have_result_q, have_result_d;

  // Accumulate only once a result exists; otherwise fall back to req_a.
  assign use_acc = acc_d & have_result_q;
`else
  logic unused_req_acc;

  assign unused_req_acc = bus.req_acc;
  assign use_acc        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_cout_d  = res_cout_q;
    op_count_d  = op_count_q;
`ifdef ALU_SEQ_ACC_EN
    acc_d         = acc_q;
    have_result_d = have_result_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
`ifdef ALU_SEQ_ACC_EN
          acc_d   = bus.req_acc;
`endif
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        res_data_d = dp_out;
        res_cout_d = dp_cout;
`ifdef ALU_SEQ_ACC_EN
        have_result_d = 1'b1;
`endif
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.res_ready) begin
          op_count_d = op_count_q + CNT_WIDTH'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath controls are decoded from the next state so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    dp_reg_addr_d = C_ADDR_NONE;
    dp_s_reg_d    = 1'b0;
    dp_in_d       = '0;
    dp_s_d        = 1'b0;
    res_valid_d   = 1'b0;
    case (state_d)
      ST_LOAD_A: begin
        dp_reg_addr_d = C_ADDR_A;
        dp_s_d        = op_d;
        if (!use_acc) begin
          dp_s_reg_d = 1'b1;
          dp_in_d    = a_d;
        end
      end
      ST_LOAD_B: begin
        dp_reg_addr_d = C_ADDR_B;
        dp_s_reg_d    = 1'b1;
        dp_in_d       = b_d;
        dp_s_d        = op_d;
      end
      ST_EXEC: dp_s_d = op_d;
      ST_WB: begin
        dp_reg_addr_d = C_ADDR_O;
        dp_s_d        = op_d;
      end
      ST_RESP: begin
        dp_s_d      = op_d;
        res_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      res_data_q    <= '0;
      res_cout_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      op_count_q    <= '0;
      dp_in_q       <= '0;
      dp_reg_addr_q <= C_ADDR_NONE;
      dp_s_reg_q    <= 1'b0;
      dp_s_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_data_q    <= res_data_d;
      res_cout_q    <= res_cout_d;
      res_valid_q   <= res_valid_d;
      op_count_q    <= op_count_d;
      dp_in_q       <= dp_in_d;
      dp_reg_addr_q <= dp_reg_addr_d;
      dp_s_reg_q    <= dp_s_reg_d;
      dp_s_q        <= dp_s_d;
    end
  end

`ifdef ALU_SEQ_ACC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= 1'b0;
      have_result_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      have_result_q <= have_result_d;
    end
  end
`endif

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_cout  = res_cout_q;
  assign busy          = (state_q != ST_IDLE);
  assign op_count      = op_count_q;
  assign dp_in         = dp_in_q;
  assign dp_reg_addr   = dp_reg_addr_q;
  assign dp_s_reg      = dp_s_reg_q;
  assign dp_s          = dp_s_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with a
//               behavioural 4-bit registered adder datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int BIT_WIDTH = 4;
  localparam int CNT_WIDTH = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 busy;
  logic [CNT_WIDTH-1:0] op_count;
  logic [BIT_WIDTH-1:0] dp_in;
  logic [1:0]           dp_reg_addr;
  logic                 dp_s_reg;
  logic                 dp_s;
  logic [BIT_WIDTH-1:0] dp_out;
  logic                 dp_cout;

  int n_checks;
  int n_fail;

  alu_sequencer_if #(.BIT_WIDTH(BIT_WIDTH)) bus ();

  alu_sequencer #(
    .BIT_WIDTH (BIT_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .op_count    (op_count),
    .dp_in       (dp_in),
    .dp_reg_addr (dp_reg_addr),
    .dp_s_reg    (dp_s_reg),
    .dp_s        (dp_s),
    .dp_out      (dp_out),
    .dp_cout     (dp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered adder datapath: A, B, O registers and a carry register
  // that captures every cycle.
  logic [BIT_WIDTH-1:0] m_a, m_b, m_o;
  logic                 m_c;
  logic [BIT_WIDTH:0]   m_sum;
  logic [BIT_WIDTH-1:0] m_mux;

  initial begin
    m_a = '0;
    m_b = '0;
    m_o = '0;
    m_c = 1'b0;
  end

  assign m_sum   = {1'b0, m_a} + {1'b0, m_b};
  assign dp_out  = m_sum[BIT_WIDTH-1:0];
  assign dp_cout = m_c;
  assign m_mux   = dp_s_reg ? dp_in : dp_out;

  always @(posedge clk) begin
    m_c <= m_sum[BIT_WIDTH];
    case (dp_reg_addr)
      2'd0:    m_a <= m_mux;
      2'd1:    m_b <= m_mux;
      2'd2:    m_o <= m_mux;
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a request and return once the handshake edge has passed.
  task automatic send_req(input logic op, input logic [3:0] a, input logic [3:0] b, input logic acc);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_acc   = acc;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_accept_timeout", (n < 20) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Count edges from the handshake edge until res_valid rises.
  task automatic wait_resp(output int n);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int lat;
  logic [1:0] seq [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3;
    seq[3] = 2'd2; seq[4] = 2'd3; seq[5] = 2'd3;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_acc   = 1'b0;
    bus.res_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    check_eq("rst_dp_reg_addr", dp_reg_addr, 3);
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_op_count", op_count, 0);
    check_eq("rst_busy", busy, 0);

    // 3 + 4
    send_req(1'b0, 4'd3, 4'd4, 1'b0);
    check_eq("loada_addr", dp_reg_addr, 0);
    check_eq("loada_s_reg", dp_s_reg, 1);
    check_eq("loada_dp_in", dp_in, 3);
    check_eq("loada_busy", busy, 1);
    wait_resp(lat);
    check_eq("add34_latency", lat, 4);
    check_eq("add34_data", bus.res_data, 7);
    check_eq("add34_cout", bus.res_cout, 0);
    check_eq("add34_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    check_eq("add34_op_count", op_count, 1);
    check_eq("add34_back_idle", bus.req_ready, 1);

    // 9 + 9 with the consumer stalling
    bus.res_ready = 1'b0;
    send_req(1'b0, 4'd9, 4'd9, 1'b0);
    wait_resp(lat);
    check_eq("add99_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_data", bus.res_data, 2);
      check_eq("hold_cout", bus.res_cout, 1);
      check_eq("hold_valid", bus.res_valid, 1);
      check_eq("hold_req_ready", bus.req_ready, 0);
      @(posedge clk);
      #1;
    end
    check_eq("hold_op_count", op_count, 1);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("add99_op_count", op_count, 2);

    // Back-to-back requests with req_valid held high
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_a     = 4'd1;
    bus.req_b     = 4'd2;
    bus.req_acc   = 1'b0;
    for (int i = 0; i < 18; i++) begin
      check_eq("b2b_handshake", bus.req_ready, (i % 6 == 0) ? 1 : 0);
      @(posedge clk);
      #1;
      check_eq("b2b_dp_reg_addr", dp_reg_addr, seq[i % 6]);
      if (i % 6 == 4)
        check_eq("b2b_data", bus.res_data, 3);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check_eq("b2b_op_count", op_count, 5);

    // Accumulate: 2 + 3, then acc with b = 5
    send_req(1'b0, 4'd2, 4'd3, 1'b0);
    wait_resp(lat);
    check_eq("acc_first_data", bus.res_data, 5);
    @(posedge clk);
    #1;
    send_req(1'b0, 4'd1, 4'd5, 1'b1);
`ifdef ALU_SEQ_ACC_EN
    check_eq("acc_s_reg", dp_s_reg, 0);
`else
    check_eq("acc_s_reg", dp_s_reg, 1);
`endif
    wait_resp(lat);
`ifdef ALU_SEQ_ACC_EN
    check_eq("acc_data", bus.res_data, 10);
`else
    check_eq("acc_data", bus.res_data, 6);
`endif
    check_eq("acc_cout", bus.res_cout, 0);
    @(posedge clk);
    #1;
    check_eq("acc_op_count", op_count, 7);

    // Reset pulse while in EXEC
    send_req(1'b0, 4'd7, 4'd7, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("exec_addr", dp_reg_addr, 3);
    check_eq("exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_req_ready", bus.req_ready, 1);
    check_eq("abort_res_valid", bus.res_valid, 0);
    check_eq("abort_op_count", op_count, 0);
    check_eq("abort_dp_reg_addr", dp_reg_addr, 3);
    check_eq("abort_res_data", bus.res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First op after reset, accumulate requested with no prior result
    send_req(1'b0, 4'd1, 4'd1, 1'b1);
    check_eq("post_rst_s_reg", dp_s_reg, 1);
    check_eq("post_rst_dp_in", dp_in, 1);
    wait_resp(lat);
    check_eq("post_rst_latency", lat, 4);
    check_eq("post_rst_data", bus.res_data, 2);
    check_eq("post_rst_cout", bus.res_cout, 0);
    @(posedge clk);
    #1;
    check_eq("post_rst_op_count", op_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
